// File: rtl/mips32_pkg.sv
// +----------------------------------------------------------------------+
// | mips32_pkg: opcodes, instruction types and fetch FSM state encoding.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    IT_RR_ALU = 3'd0,
    IT_RM_ALU = 3'd1,
    IT_LOAD   = 3'd2,
    IT_STORE  = 3'd3,
    IT_BRANCH = 3'd4,
    IT_HALT   = 3'd5
  } instr_type_e;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_REQ     = 2'd1,
    FS_DISCARD = 2'd2,
    FS_HALT    = 2'd3
  } fetch_state_e;

  function automatic logic is_hlt(input logic [5:0] opcode);
    return opcode == OP_HLT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips32_prefetch_fifo.sv
// +----------------------------------------------------------------------+
// | mips32_prefetch_fifo: DEPTH-entry FIFO with flush, combinational head.|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module mips32_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk1,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/mips32_fetch_unit.sv
// +----------------------------------------------------------------------+
// | mips32_fetch_unit: imem req/ack fetch FSM, PC, redirect and prefetch. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module mips32_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ir,
  output logic [31:0] out_npc,
  output logic        halted
);
  import mips32_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e  state_q;
  logic [31:0]   pc_q;
  logic          req_q;
  logic [31:0]   addr_q;
  logic          halted_q;

  logic [CW-1:0] count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [63:0]   head;
  logic [31:0]   pc_inc;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_after_push;

  assign pc_inc    = pc_q + 32'd1;
  assign out_valid = !fifo_empty && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push      = (state_q == FS_REQ) && req_q && imem_ack && !redirect_valid;
  assign count_after_push = count + CW'(1) - CW'(pop);

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign halted    = halted_q;
  assign out_ir    = fifo_empty ? 32'h0 : head[63:32];
  assign out_npc   = fifo_empty ? 32'h0 : head[31:0];

  mips32_prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk1    (clk1),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i ({imem_rdata, pc_inc}),
    .rdata_o (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q  <= FS_IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= 32'h0;
      halted_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q     <= redirect_pc;
      halted_q <= 1'b0;
      // An open handshake must finish before the new target can be requested.
      if ((state_q == FS_REQ || state_q == FS_DISCARD) && !imem_ack) begin
        state_q <= FS_DISCARD;
      end else begin
        state_q <= FS_REQ;
        req_q   <= 1'b1;
        addr_q  <= redirect_pc;
      end
    end else begin
      case (state_q)
        FS_IDLE: begin
          if (!fifo_full) begin
            state_q <= FS_REQ;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        FS_REQ: begin
          if (imem_ack) begin
            pc_q <= pc_inc;
            if (is_hlt(imem_rdata[31:26])) begin
              state_q  <= FS_HALT;
              req_q    <= 1'b0;
              halted_q <= 1'b1;
            end else if (count_after_push < DEPTH_C) begin
              addr_q <= pc_inc;
            end else begin
              state_q <= FS_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        FS_DISCARD: begin
          if (imem_ack) begin
            if (!fifo_full) begin
              state_q <= FS_REQ;
              addr_q  <= pc_q;
            end else begin
              state_q <= FS_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        FS_HALT: begin
          req_q <= 1'b0;
        end
        default: begin
          state_q <= FS_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips32_fetch_unit.sv
// +----------------------------------------------------------------------+
// | tb_mips32_fetch_unit: directed bench for the fetch front end.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mips32_fetch_unit;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } pop_t;

  logic        clk1 = 1'b0;
  logic        rst, rst2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        out_valid, out_ready, halted;
  logic [31:0] out_ir, out_npc;

  logic        req2, ack2, ov2, ready2, halted2, en2;
  logic [31:0] addr2, rdata2, ir2, npc2;

  int          lat;
  logic        hlt_en;
  logic [31:0] hlt_addr;
  int          wait_cnt;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  logic [31:0] ack_q[$];
  int          ack_cyc[$];
  pop_t        pop_q[$];
  logic [31:0] ack2_q[$];
  pop_t        pop2_q[$];

  always #5 clk1 = ~clk1;

  mips32_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk1(clk1), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_npc(out_npc),
    .halted(halted)
  );

  mips32_fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFFFFFE)) u_dut2 (
    .clk1(clk1), .rst(rst2), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
    .out_valid(ov2), .out_ready(ready2), .out_ir(ir2), .out_npc(npc2),
    .halted(halted2)
  );

  // ADDI r1,r0,addr[15:0] everywhere, except an optional HLT word.
  function automatic logic [31:0] memword(input logic [31:0] a, input logic hen,
                                          input logic [31:0] ha);
    if (hen && a == ha) return 32'hFC000000;
    return 32'h28010000 | {16'h0, a[15:0]};
  endfunction

  always @(posedge clk1 or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always @(posedge clk1) cyc <= cyc + 1;

  always_comb begin
    imem_ack   = imem_req && (wait_cnt >= lat);
    imem_rdata = memword(imem_addr, hlt_en, hlt_addr);
    ack2       = req2 && en2;
    rdata2     = memword(addr2, 1'b0, 32'h0);
  end

  always @(negedge clk1) begin
    #2;
    if (!rst) begin
      if (imem_req && imem_ack) begin
        ack_q.push_back(imem_addr);
        ack_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) pop_q.push_back({out_ir, out_npc});
    end
    if (!rst2) begin
      if (req2 && ack2) ack2_q.push_back(addr2);
      if (ov2 && ready2) pop2_q.push_back({ir2, npc2});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k = 0;
    while (pop_q.size() < n && k < budget) begin
      @(negedge clk1);
      k++;
    end
    #3;
    chk("pop_wait", 32'(pop_q.size() >= n), 32'd1);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clk1);
    @(negedge clk1);
    ack_q.delete();
    ack_cyc.delete();
    pop_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1; rst2 = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    out_ready = 1'b0; lat = 0; hlt_en = 1'b0; hlt_addr = 32'h0; en2 = 1'b1; ready2 = 1'b1;

    // Reset state
    @(negedge clk1); #1;
    chk("rst_req",    imem_req,  32'h0);
    chk("rst_addr",   imem_addr, 32'h0);
    chk("rst_valid",  out_valid, 32'h0);
    chk("rst_ir",     out_ir,    32'h0);
    chk("rst_npc",    out_npc,   32'h0);
    chk("rst_halted", halted,    32'h0);
    chk("rst_count",  32'(u_dut.u_fifo.count_o), 32'h0);

    // Zero-wait memory, consumer always ready
    out_ready = 1'b1; lat = 0;
    do_reset();
    wait_pops(4, 40);
    for (int i = 0; i < 4; i++) begin
      chk("s1_ir",   pop_q[i].ir,  32'h28010000 + 32'(i));
      chk("s1_npc",  pop_q[i].npc, 32'(i + 1));
      chk("s1_addr", ack_q[i],     32'(i));
    end
    chk("s1_b2b", 32'(ack_cyc[3] - ack_cyc[0]), 32'd3);

    // Consumer stalled: FIFO fills to DEPTH, then fetch pauses and resumes
    out_ready = 1'b0;
    do_reset();
    repeat (12) @(negedge clk1);
    #1;
    chk("s2_acks",  32'(ack_q.size()), 32'd4);
    chk("s2_req",   imem_req, 32'h0);
    chk("s2_count", 32'(u_dut.u_fifo.count_o), 32'd4);
    chk("s2_valid", out_valid, 32'h1);
    chk("s2_head",  out_npc, 32'd1);
    out_ready = 1'b1;
    wait_pops(8, 60);
    for (int i = 0; i < 8; i++) begin
      chk("s2_npc",  pop_q[i].npc, 32'(i + 1));
      chk("s2_ir",   pop_q[i].ir,  32'h28010000 + 32'(i));
      chk("s2_addr", ack_q[i],     32'(i));
    end

    // Slow memory, redirect while the request to addr 5 is open
    lat = 3; out_ready = 1'b1;
    do_reset();
    k = 0;
    while (!(imem_req && imem_addr == 32'd5) && k < 100) begin
      @(negedge clk1);
      k++;
    end
    chk("s3_req5", 32'(imem_req && imem_addr == 32'd5), 32'd1);
    @(negedge clk1);
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    #1;
    chk("s3_noack", imem_ack, 32'h0);
    chk("s3_rv_valid", out_valid, 32'h0);
    @(negedge clk1);
    redirect_valid = 1'b0;
    #1;
    chk("s3_disc_req",  imem_req,  32'h1);
    chk("s3_disc_addr", imem_addr, 32'd5);
    wait_pops(6, 80);
    chk("s3_npc4",  pop_q[4].npc, 32'd5);
    chk("s3_npc5",  pop_q[5].npc, 32'h21);
    chk("s3_ir5",   pop_q[5].ir,  32'h28010020);
    chk("s3_stale", ack_q[5], 32'd5);
    chk("s3_tgt",   ack_q[6], 32'h20);

    // Redirect coinciding with an ack and a valid head
    lat = 0; out_ready = 1'b0;
    do_reset();
    k = 0;
    while (u_dut.u_fifo.count_o != 3'd2 && k < 20) begin
      @(negedge clk1);
      k++;
    end
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("s4_ack",   imem_ack,  32'h1);
    chk("s4_valid", out_valid, 32'h0);
    @(negedge clk1);
    redirect_valid = 1'b0;
    #1;
    chk("s4_count", 32'(u_dut.u_fifo.count_o), 32'h0);
    chk("s4_empty", out_valid, 32'h0);
    chk("s4_req",   imem_req,  32'h1);
    chk("s4_addr",  imem_addr, 32'h40);
    wait_pops(1, 20);
    chk("s4_npc", pop_q[0].npc, 32'h41);
    chk("s4_ir",  pop_q[0].ir,  32'h28010040);

    // HLT at addr 2, then redirect out of HALT
    lat = 0; out_ready = 1'b1; hlt_en = 1'b1; hlt_addr = 32'd2;
    do_reset();
    wait_pops(3, 30);
    repeat (8) @(negedge clk1);
    #1;
    chk("s5_pops",   32'(pop_q.size()), 32'd3);
    chk("s5_hlt_ir", pop_q[2].ir,  32'hFC000000);
    chk("s5_hlt_np", pop_q[2].npc, 32'd3);
    chk("s5_halted", halted,   32'h1);
    chk("s5_req",    imem_req, 32'h0);
    chk("s5_acks",   32'(ack_q.size()), 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    @(negedge clk1);
    redirect_valid = 1'b0; hlt_en = 1'b0;
    #1;
    chk("s5_unhalt", halted,    32'h0);
    chk("s5_rreq",   imem_req,  32'h1);
    chk("s5_raddr",  imem_addr, 32'h10);
    wait_pops(4, 30);
    chk("s5_npc", pop_q[3].npc, 32'h11);

    // PC wrap from RESET_PC = FFFFFFFE, then asynchronous reset mid-request
    rst2 = 1'b0;
    k = 0;
    while (pop2_q.size() < 3 && k < 30) begin
      @(negedge clk1);
      k++;
    end
    #3;
    chk("s6_a0", ack2_q[0], 32'hFFFFFFFE);
    chk("s6_a1", ack2_q[1], 32'hFFFFFFFF);
    chk("s6_a2", ack2_q[2], 32'h00000000);
    chk("s6_n0", pop2_q[0].npc, 32'hFFFFFFFF);
    chk("s6_n1", pop2_q[1].npc, 32'h00000000);
    chk("s6_n2", pop2_q[2].npc, 32'h00000001);
    chk("s6_i0", pop2_q[0].ir,  32'h2801FFFE);
    chk("s6_i2", pop2_q[2].ir,  32'h28010000);
    ready2 = 1'b0; en2 = 1'b0;
    @(negedge clk1);
    #1;
    chk("s6_pre_req", req2, 32'h1);
    chk("s6_pre_cnt", 32'(u_dut2.u_fifo.count_o != 3'd0), 32'h1);
    #1;
    rst2 = 1'b1;
    #1;
    chk("s6_arst_req",   req2,  32'h0);
    chk("s6_arst_addr",  addr2, 32'h0);
    chk("s6_arst_cnt",   32'(u_dut2.u_fifo.count_o), 32'h0);
    chk("s6_arst_valid", ov2,   32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
